// File: rtl/skein_pkg.sv
// Shared constants and encodings for the Threefish-1024 round sequencer.
package skein_pkg;
  localparam int NUM_WORDS      = 16;
  localparam int NUM_ROUNDS     = 80;
  localparam int ROUNDS_PER_KEY = 4;
  localparam int NUM_SUBKEYS    = NUM_ROUNDS / ROUNDS_PER_KEY + 1;

  localparam int WORD_W   = 4;
  localparam int ROUND_W  = 7;
  localparam int SUBKEY_W = 5;

  localparam logic [SUBKEY_W-1:0] LAST_SUBKEY = SUBKEY_W'(NUM_SUBKEYS - 1);
  localparam logic [ROUND_W-1:0]  KEY_MASK    = ROUND_W'(ROUNDS_PER_KEY - 1);

  typedef enum logic [1:0] {
    MODE_KEYGEN = 2'b00,
    MODE_KEYADD = 2'b01,
    MODE_MIX    = 2'b10,
    MODE_IDLE   = 2'b11
  } chip_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYGEN,
    ST_KEYADD,
    ST_MIX,
    ST_DONE
  } state_t;
endpackage

// File: rtl/skein_word_counter.sv
// Per-phase word index; wraps naturally at the phase boundary.
module skein_word_counter
  import skein_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en,
  input  logic              clr,
  output logic [WORD_W-1:0] count,
  output logic              last_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) count <= '0;
    else if (en)      count <= count + 1'b1;
  end

  assign last_o = (count == WORD_W'(NUM_WORDS - 1));

endmodule

// File: rtl/skein_round_sequencer.sv
// Block sequencer: interleaves 21 subkey gen/add phases with 80 mix rounds.
module skein_round_sequencer
  import skein_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                hold_i,
  output logic [WORD_W-1:0]   word_counter_o,
  output logic [ROUND_W-1:0]  round_counter_o,
  output logic [SUBKEY_W-1:0] subkey_idx_o,
  output logic [1:0]          chip_mode_o,
  output logic                word_en_o,
  output logic                busy_o,
  output logic                done_o
);

  state_t               state, state_nxt;
  logic [ROUND_W-1:0]   round, round_nxt, round_inc;
  logic [SUBKEY_W-1:0]  subkey, subkey_nxt;
  logic                 word_last, phase_end;
  chip_mode_t           mode;

  assign busy_o    = (state == ST_KEYGEN) || (state == ST_KEYADD) || (state == ST_MIX);
  assign word_en_o = busy_o && !hold_i;
  assign phase_end = word_en_o && word_last;
  assign round_inc = round + 1'b1;

  skein_word_counter u_word (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en     (word_en_o),
    .clr    (!busy_o),
    .count  (word_counter_o),
    .last_o (word_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      round  <= '0;
      subkey <= '0;
    end else begin
      state  <= state_nxt;
      round  <= round_nxt;
      subkey <= subkey_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    round_nxt  = round;
    subkey_nxt = subkey;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt  = ST_KEYGEN;
          round_nxt  = '0;
          subkey_nxt = '0;
        end
      end
      ST_KEYGEN: if (phase_end) state_nxt = ST_KEYADD;
      ST_KEYADD: begin
        if (phase_end) begin
          if (subkey == LAST_SUBKEY) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt  = ST_MIX;
            subkey_nxt = subkey + 1'b1;
          end
        end
      end
      ST_MIX: begin
        if (phase_end) begin
          round_nxt = round_inc;
          // rounds-per-key is a power of two: low bits of round+1 zero means inject
          if ((round_inc & KEY_MASK) == '0) state_nxt = ST_KEYGEN;
        end
      end
      ST_DONE: begin
        state_nxt  = ST_IDLE;
        round_nxt  = '0;
        subkey_nxt = '0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mode = MODE_IDLE;
    case (state)
      ST_KEYGEN: mode = MODE_KEYGEN;
      ST_KEYADD: mode = MODE_KEYADD;
      ST_MIX:    mode = MODE_MIX;
      default:   mode = MODE_IDLE;
    endcase
  end

  assign chip_mode_o     = mode;
  assign round_counter_o = round;
  assign subkey_idx_o    = subkey;
  assign done_o          = (state == ST_DONE);

endmodule

// File: tb/tb_skein_round_sequencer.sv
// Cycle-level check of the sequencer against a precomputed phase schedule.
module tb_skein_round_sequencer;
  localparam int NB = 1952;

  logic       clk = 1'b0;
  logic       rst, start, hold;
  logic [3:0] word_counter;
  logic [6:0] round_counter;
  logic [4:0] subkey_idx;
  logic [1:0] chip_mode;
  logic       word_en, busy, done;

  skein_round_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .hold_i          (hold),
    .word_counter_o  (word_counter),
    .round_counter_o (round_counter),
    .subkey_idx_o    (subkey_idx),
    .chip_mode_o     (chip_mode),
    .word_en_o       (word_en),
    .busy_o          (busy),
    .done_o          (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected busy-cycle schedule, one entry per unheld busy cycle
  logic [1:0] s_mode  [NB];
  logic [3:0] s_word  [NB];
  logic [6:0] s_round [NB];
  logic [4:0] s_sub   [NB];

  task automatic build_schedule();
    int n = 0;
    for (int k = 0; k <= 20; k++) begin
      for (int p = 0; p < 2; p++)
        for (int w = 0; w < 16; w++) begin
          s_mode[n] = 2'(p); s_word[n] = 4'(w); s_round[n] = 7'(4*k); s_sub[n] = 5'(k); n++;
        end
      if (k < 20)
        for (int r = 0; r < 4; r++)
          for (int w = 0; w < 16; w++) begin
            s_mode[n] = 2'b10; s_word[n] = 4'(w); s_round[n] = 7'(4*k + r); s_sub[n] = 5'(k + 1); n++;
          end
    end
  endtask

  typedef enum {P_IDLE, P_BUSY, P_DONE} phase_t;
  phase_t ph = P_IDLE;
  int idx = 0;
  int cyc_no = 0, start_cyc = 0, done_at = -1, busy_cnt = 0, held = 0;
  bit directed = 1'b0;

  function automatic logic [20:0] expect_vec(input logic h);
    case (ph)
      P_BUSY:  return {s_mode[idx], s_word[idx], s_round[idx], s_sub[idx], 1'b1, 1'b0, !h};
      P_DONE:  return {2'b11, 4'd0, 7'd80, 5'd20, 1'b0, 1'b1, 1'b0};
      default: return {2'b11, 4'd0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0};
    endcase
  endfunction

  task automatic cyc(input logic s, input logic h, input logic r);
    int off;
    start = s; hold = h; rst = r;
    #1;
    off = cyc_no - start_cyc;
    check("outputs", {11'd0, chip_mode, word_counter, round_counter, subkey_idx, busy, done, word_en},
          {11'd0, expect_vec(h)});
    if (busy) busy_cnt++;
    if (done && done_at < 0) done_at = off;
    if (directed) begin
      if (off == 81)   check("round2_stays_mix", {23'd0, chip_mode, round_counter}, {23'd0, 2'b10, 7'd3});
      if (off == 97)   check("round3_to_keygen", {18'd0, chip_mode, round_counter, subkey_idx},
                             {18'd0, 2'b00, 7'd4, 5'd1});
      if (off == 1952) check("last_keyadd", {21'd0, chip_mode, word_counter, subkey_idx},
                             {21'd0, 2'b01, 4'd15, 5'd20});
      if (off == 1953) check("done_pulse", {31'd0, done}, 32'd1);
    end
    if (ph == P_BUSY && h && !r) held++;
    @(posedge clk);
    if (r) ph = P_IDLE;
    else case (ph)
      P_IDLE: if (s) begin ph = P_BUSY; idx = 0; start_cyc = cyc_no; end
      P_BUSY: if (!h) begin if (idx == NB - 1) ph = P_DONE; else idx++; end
      default: ph = P_IDLE;
    endcase
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic run_block(input bit dir, input int hold_at, input int hold_len, input int hold_pct,
                           input int start_at, input int rst_at);
    int i;
    logic h, s, r;
    done_at = -1; busy_cnt = 0; held = 0; directed = dir;
    cyc(1'b1, 1'b0, 1'b0);
    i = 1;
    while (ph != P_IDLE && i < 4000) begin
      h = (i >= hold_at && i < hold_at + hold_len) || ($urandom_range(99) < hold_pct);
      s = (i == start_at) || (ph == P_DONE) || (hold_pct > 0 && $urandom_range(1) == 1);
      r = (i == rst_at);
      cyc(s, h, r);
      i++;
    end
    directed = 1'b0;
    check("within_budget", 32'(i >= 4000), 32'd0);
    if (rst_at < 0) begin
      check("done_latency", 32'(done_at), 32'(1953 + held));
      check("busy_cycles", 32'(busy_cnt), 32'(1952 + held));
    end else begin
      check("no_done_after_reset", 32'(done_at), 32'hffff_ffff);
    end
  endtask

  initial begin
    build_schedule();
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    cyc(1'b0, 1'b0, 1'b1);
    check("reset_mode", {30'd0, chip_mode}, 32'd3);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    // clean run, stray start at 500, start during DONE
    run_block(1'b1, -10, 0, 0, 500, -1);
    // restart right after DONE, hold 5 cycles at first MIX word 7
    run_block(1'b0, 40, 5, 0, -1, -1);
    check("hold_delay", 32'(held), 32'd5);
    // random holds and stray starts
    run_block(1'b0, -10, 0, 25, -1, -1);
    // reset in the middle of a MIX phase
    run_block(1'b0, -10, 0, 0, -1, 720);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
